// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmitter states and bit-period helper.
package uart_pkg;

    localparam int unsigned UartDataBits = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
        return (clk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered full/empty flags and an occupancy count.
module uart_tx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           wr_data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rd_data_c,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] level_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned LevelW = $clog2(Depth + 1);

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [LevelW-1:0] level_q;
    logic [LevelW-1:0] level_d;
    logic              full_q;
    logic              empty_q;
    logic              push_ok;
    logic              pop_ok;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    always_comb begin
        push_ok = push_i && !full_q;
        pop_ok  = pop_i && !empty_q;
        level_d = level_q + LevelW'(push_ok) - LevelW'(pop_ok);
    end

    // Pointers, occupancy and flags; flags are computed from the next level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            level_q <= level_d;
            full_q  <= (level_d == LevelW'(Depth));
            empty_q <= (level_d == '0);
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_c = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = level_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a start/data/stop serializer.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned ClkFreq   = 18000000,
    parameter int unsigned BaudRate  = 115200,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [UartDataBits-1:0]        data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic                           tx_o,
    output logic                           busy_o,
    output logic [$clog2(FifoDepth+1)-1:0] level_o
);

    localparam int unsigned Div    = baud_div(ClkFreq, BaudRate);
    localparam int unsigned CntW   = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned BitW   = $clog2(UartDataBits);
    localparam int unsigned LevelW = $clog2(FifoDepth + 1);

    tx_state_e               state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [BitW-1:0]         bit_q, bit_d;
    logic [UartDataBits-1:0] shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [UartDataBits-1:0] fifo_rd_data;
    logic                    push;
    logic                    pop;
    logic [LevelW-1:0]       level_nxt;

    assign push    = valid_i && !fifo_full;
    assign ready_o = !fifo_full;

    uart_tx_fifo #(
        .Width (UartDataBits),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push),
        .wr_data_i (data_i),
        .pop_i     (pop),
        .rd_data_c (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level_o)
    );

    // Serializer state and line register; tx is computed from the next state so it is a pure flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, line value and FIFO pop; STOP chains straight into START when data waits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    cnt_d   = CntW'(Div - 1);
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(Div - 1);
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            TX_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CntW'(Div - 1);
                    if (bit_q == BitW'(UartDataBits - 1)) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_d   = bit_q + BitW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            TX_STOP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        cnt_d   = CntW'(Div - 1);
                        tx_d    = 1'b0;
                        state_d = TX_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = TX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = TX_IDLE;
            end
        endcase

        level_nxt = level_o + LevelW'(push) - LevelW'(pop);
        busy_d    = (state_d != TX_IDLE) || (level_nxt != '0);
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule
